// File: rtl/tomasula_types.sv
// tomasula_types: shared constants and types for the Tomasulo core
package tomasula_types;
  localparam int NUM_RS_DEFAULT = 4;
  typedef logic [$clog2(NUM_RS_DEFAULT)-1:0] rs_idx_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after base
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  // Scanning from the farthest offset down leaves the nearest hit in idx; N is a power of two so the sum wraps.
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) idx = req[base + W'(k)] ? base + W'(k) : idx;
  end
  assign any = |req;
  assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/rs_scheduler.sv
// rs_scheduler: dispatch allocation and ALU issue arbitration for the reservation-station bank
module rs_scheduler
  import tomasula_types::*;
#(
  parameter int NUM_RS = NUM_RS_DEFAULT,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      dispatch_valid,
  output logic                      dispatch_ready,
  input  logic [NUM_RS-1:0]         rs_empty,
  input  logic [NUM_RS-1:0]         rs_ready,
  output logic [NUM_RS-1:0]         load_word,
  input  logic                      alu_ext_free,
  output logic [NUM_RS-1:0]         alu_free,
  output logic [$clog2(NUM_RS)-1:0] issue_idx
);
  localparam int W = $clog2(NUM_RS);
  logic [NUM_RS-1:0] alloc_pend, issue_pend, disp_grant, iss_grant;
  logic [W-1:0] disp_ptr, iss_ptr, disp_idx, iss_idx;
  logic [2:0] busy_cnt;
  logic disp_any, iss_any, disp_go, iss_go;
  rr_picker #(.N(NUM_RS)) u_disp (
    .req(rs_empty & ~alloc_pend),
    .base(disp_ptr),
    .grant(disp_grant),
    .idx(disp_idx),
    .any(disp_any)
  );
  rr_picker #(.N(NUM_RS)) u_iss (
    .req(rs_ready & ~issue_pend),
    .base(iss_ptr),
    .grant(iss_grant),
    .idx(iss_idx),
    .any(iss_any)
  );
  assign dispatch_ready = disp_any & ~flush & ~rst;
  assign disp_go = dispatch_valid & dispatch_ready;
  assign iss_go = iss_any & (busy_cnt == 3'd0) & alu_ext_free & ~flush;
  // Pend bits hold a station out of arbitration until it acknowledges by dropping its request line.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_pend <= '0;
      issue_pend <= '0;
      disp_ptr <= '0;
      iss_ptr <= '0;
      busy_cnt <= '0;
      load_word <= '0;
      alu_free <= '0;
      issue_idx <= '0;
    end else if (flush) begin
      alloc_pend <= '0;
      issue_pend <= '0;
      busy_cnt <= '0;
      load_word <= '0;
      alu_free <= '0;
    end else begin
      load_word <= disp_go ? disp_grant : '0;
      alloc_pend <= (alloc_pend & rs_empty) | (disp_go ? disp_grant : '0);
      disp_ptr <= disp_go ? disp_idx + W'(1) : disp_ptr;
      alu_free <= iss_go ? iss_grant : '0;
      issue_idx <= iss_go ? iss_idx : issue_idx;
      issue_pend <= (issue_pend & rs_ready) | (iss_go ? iss_grant : '0);
      iss_ptr <= iss_go ? iss_idx + W'(1) : iss_ptr;
      busy_cnt <= iss_go ? 3'(ALU_LAT) : busy_cnt - 3'(busy_cnt != 3'd0);
    end
  end
endmodule

// File: doc/rs_scheduler.md
# rs_scheduler

Scheduler for the reservation-station bank of the Tomasulo core. Allocates each decoded instruction to a free reservation station (dispatch) and arbitrates the single shared ALU among stations whose operands are valid (issue), using independent round-robin pointers. Sits between decode/ROB allocation and the `reservation_station` instances. Also drives each station's `alu_free` input.

## Interface
Parameters:
- `NUM_RS`, 4: number of reservation stations (power of two, ≥2).
- `ALU_LAT`, 1: ALU occupancy in cycles per issued op (1–7).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush (mispredict); synchronous.
- `dispatch_valid` in 1: decode holds an instruction for allocation.
- `dispatch_ready` out 1: allocation possible this cycle (combinational).
- `rs_empty` in `NUM_RS`: per-station `res_empty`.
- `rs_ready` in `NUM_RS`: per-station operands-valid, awaiting ALU (STALL/PEEK with both valid).
- `load_word` out `NUM_RS`: one-hot load strobe to stations (registered).
- `alu_ext_free` in 1: ALU-side availability.
- `alu_free` out `NUM_RS`: per-station grant, one-hot or zero (registered).
- `issue_idx` out `$clog2(NUM_RS)`: index of the currently granted station, valid when `|alu_free`.

## Operation
- Dispatch candidates: `rs_empty & ~alloc_pend`. `dispatch_ready = |candidates & ~flush`.
- On `dispatch_valid & dispatch_ready`: pick the first candidate at or after `disp_ptr` (wrapping), register its bit into `load_word`, set its `alloc_pend` bit, and set `disp_ptr` to the winner+1 mod `NUM_RS`.
- `alloc_pend[i]` clears when `rs_empty[i]` samples 0. It also clears on flush.
- Issue candidates: `rs_ready & ~issue_pend`. Issue is eligible when `busy_cnt == 0`, `alu_ext_free` is 1, and `flush` is 0.
- On an issue: pick the first candidate at or after `iss_ptr`, register a one-hot `alu_free` and `issue_idx`, set `issue_pend[i]`, set `iss_ptr` to winner+1, and load `busy_cnt = ALU_LAT`.
- `alu_free` is a single-cycle pulse.
- `busy_cnt` decrements to 0 each cycle and saturates at 0.
- `issue_pend[i]` clears when `rs_ready[i]` samples 0, i.e. the station entered EXEC.
- Simultaneous dispatch and issue to the same or different stations are independent and both allowed.
- Flush clears `alloc_pend`, `issue_pend`, `busy_cnt`, `load_word`, and `alu_free`. Pointers are kept.
- Pointer wrap: `NUM_RS-1` + 1 → 0.

## Timing
- Reset values: `load_word=0`, `alu_free=0`, `issue_idx=0`, `dispatch_ready=0` during the reset cycle, pointers 0, pend masks 0, `busy_cnt=0`.
- `load_word` and `alu_free` are asserted the cycle after the winning request is sampled (1-cycle latency). Each is high for exactly one cycle.
- With `ALU_LAT=1`, back-to-back issues are possible every other cycle per busy gap. The next grant can be issued the cycle after the previous `alu_free` pulse at the earliest.
- No station receives a second `load_word` before its `rs_empty` drops.
- No station receives a second `alu_free` before its `rs_ready` drops.
- Reset or flush in the same cycle as a request: the request is dropped and the next-cycle outputs are 0.

## Structure
- Shared package `tomasula_types`: add `NUM_RS_DEFAULT` and `rs_idx_t`.
- One sub-module `rr_picker`, instantiated twice (dispatch and issue):
  - Inputs: request vector and base pointer.
  - Outputs: one-hot grant, index, and any-bit flag.
  - Purely combinational.
- Two pend masks, two pointers, `busy_cnt`, and output registers live in the top module.

## Test plan
- **Reset:** after reset, `rs_empty=4'b1111`, `dispatch_valid=1` → `load_word` sequence `0001,0010,0100,1000` over 4 cycles (`rs_empty` dropped by the bench one cycle after each strobe).
- **Masking:** `rs_empty` held at `4'b0011` and not dropped, `dispatch_valid=1` → `0001` then `0010`, then `dispatch_ready=0`. No repeats.
- **Issue arbitration:** `rs_ready=4'b1010`, `alu_ext_free=1`, `ALU_LAT=1`, `iss_ptr=0` → `alu_free=0010` (idx 1), then after the gap `1000` (idx 3).
- **ALU busy:** `ALU_LAT=3`, `rs_ready=4'b1111` → grants spaced 4 cycles apart in order 0,1,2,3. With `alu_ext_free=0`, no grant.
- **Flush:** flush the cycle after a dispatch request with issue pending → next-cycle `load_word=0`, `alu_free=0`, masks cleared, and the next grant is issued to a still-ready station.
- **Concurrency:** dispatch to station 2 and issue from station 0 in the same cycle → both strobes are asserted together the next cycle.
